// File: rtl/bus_monitor_core_if.sv
// A8 bus-side signal bundle: the sampled phi2 clock and the four timing strobes.
`timescale 1ns/1ps
interface bus_monitor_core_if;
  logic a8_clk;
  logic a8_addr_strobe;
  logic a8_write_strobe;
  logic a8_read_strobe;
  logic a8_clk_falling;

  // master drives the A8 clock and consumes strobes; slave is the monitor itself
  modport master (
    output a8_clk,
    input  a8_addr_strobe,
    input  a8_write_strobe,
    input  a8_read_strobe,
    input  a8_clk_falling
  );

  modport slave (
    input  a8_clk,
    output a8_addr_strobe,
    output a8_write_strobe,
    output a8_read_strobe,
    output a8_clk_falling
  );
endinterface

// File: rtl/bus_monitor_core.sv
// Synchronises A8 phi2 into the FPGA clock domain and emits single-cycle strobes
// marking address-valid, write-data-valid and read-deadline points of each A8 cycle.
`timescale 1ns/1ps
module bus_monitor_core #(
  parameter int ADDR_CYCLES  = 32,
  parameter int WRITE_CYCLES = 81,
  parameter int READ_CYCLES  = 94
) (
  input  logic              clk,
  input  logic              a8_rst_n,
  bus_monitor_core_if.slave bus
);

  // Strobes are registered, so each decode matches one count earlier than its output cycle.
  localparam logic [7:0] ADDR_HIT  = 8'(ADDR_CYCLES - 1);
  localparam logic [7:0] WRITE_HIT = 8'(WRITE_CYCLES - 1);
  localparam logic [7:0] READ_HIT  = 8'(READ_CYCLES - 1);
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [7:0] cnt_q, cnt_d;
  logic       active_q, active_d;
  logic       fall_q, fall_d;
  logic       addr_q, addr_d;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic       fall_det;

  always_comb begin
    s1_d     = bus.a8_clk;
    s2_d     = s1_q;
    s3_d     = s2_q;
    fall_det = s3_q & ~s2_q;

    cnt_d    = cnt_q;
    active_d = active_q;
    if (fall_det) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A new edge wins over any strobe landing on the same cycle.
    fall_d  = fall_det;
    addr_d  = active_q & ~fall_det & (cnt_q == ADDR_HIT);
    write_d = active_q & ~fall_det & (cnt_q == WRITE_HIT);
    read_d  = active_q & ~fall_det & (cnt_q == READ_HIT);
  end

  always_ff @(posedge clk or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      fall_q   <= 1'b0;
      addr_q   <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      fall_q   <= fall_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      read_q   <= read_d;
    end
  end

  assign bus.a8_clk_falling  = fall_q;
  assign bus.a8_addr_strobe  = addr_q;
  assign bus.a8_write_strobe = write_q;
  assign bus.a8_read_strobe  = read_q;

endmodule

// File: tb/tb_bus_monitor_core.sv
// Scoreboard bench: two monitor instances (default and 2/3/4 timing) share one A8 clock;
// each A8 fall pushes the expected pulse cycles, a monitor process pops them as pulses appear.
`timescale 1ns/1ps
module tb_bus_monitor_core;

  localparam int A_ADDR = 32, A_WRITE = 81, A_READ = 94;
  localparam int B_ADDR = 2,  B_WRITE = 3,  B_READ = 4;
  localparam int DET = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic a8_rst_n;
  logic a8_clk;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_a[$];
  ev_t  exp_b[$];

  bus_monitor_core_if bus_a ();
  bus_monitor_core_if bus_b ();

  assign bus_a.a8_clk = a8_clk;
  assign bus_b.a8_clk = a8_clk;

  bus_monitor_core u_dut_a (
    .clk      (clk),
    .a8_rst_n (a8_rst_n),
    .bus      (bus_a.slave)
  );

  bus_monitor_core #(
    .ADDR_CYCLES  (B_ADDR),
    .WRITE_CYCLES (B_WRITE),
    .READ_CYCLES  (B_READ)
  ) u_dut_b (
    .clk      (clk),
    .a8_rst_n (a8_rst_n),
    .bus      (bus_b.slave)
  );

  always #2.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [3:0] obs_a = {bus_a.a8_read_strobe, bus_a.a8_write_strobe,
                      bus_a.a8_addr_strobe, bus_a.a8_clk_falling};
  wire [3:0] obs_b = {bus_b.a8_read_strobe, bus_b.a8_write_strobe,
                      bus_b.a8_addr_strobe, bus_b.a8_clk_falling};

  // Monitor: kind 0=falling 1=addr 2=write 3=read
  always @(posedge clk) begin
    ev_t e;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (obs_a[k]) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL mon_a unexpected pulse kind=%0d at cyc=%0d, none required", k, cyc);
        end else begin
          e = exp_a.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL mon_a got kind=%0d cyc=%0d, required kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
          end
        end
      end
      if (obs_b[k]) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL mon_b unexpected pulse kind=%0d at cyc=%0d, none required", k, cyc);
        end else begin
          e = exp_b.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL mon_b got kind=%0d cyc=%0d, required kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drop a8_clk now; mask selects which of A's pulses survive for this cycle.
  task automatic fall_now(input logic [3:0] a_mask);
    int e;
    a8_clk = 1'b0;
    e = cyc;
    if (a_mask[0]) exp_a.push_back('{0, e + DET});
    if (a_mask[1]) exp_a.push_back('{1, e + DET + A_ADDR});
    if (a_mask[2]) exp_a.push_back('{2, e + DET + A_WRITE});
    if (a_mask[3]) exp_a.push_back('{3, e + DET + A_READ});
    exp_b.push_back('{0, e + DET});
    exp_b.push_back('{1, e + DET + B_ADDR});
    exp_b.push_back('{2, e + DET + B_WRITE});
    exp_b.push_back('{3, e + DET + B_READ});
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL %s missing pulses: pending_a=%0d pending_b=%0d, required 0/0", name, exp_a.size(), exp_b.size());
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (obs_a != 4'b0 || obs_b != 4'b0) begin
      errors++;
      $display("FAIL %s outputs a=%b b=%b, required 0000/0000", name, obs_a, obs_b);
    end
  endtask

  initial begin
    a8_rst_n = 1'b0;
    a8_clk   = 1'b1;
    step(3);
    chk_zero("reset_state");
    a8_clk = 1'b0; step(10);
    a8_clk = 1'b1; step(10);
    chk_zero("reset_held_toggle");

    // release while a8_clk is low: no pulse until a real 1->0
    a8_clk = 1'b0; step(5);
    a8_rst_n = 1'b1; step(30);
    a8_clk = 1'b1; step(30);
    drain("release_low");

    // free-running, 112 clk per A8 cycle
    repeat (3) begin
      fall_now(4'hF); step(56);
      a8_clk = 1'b1;  step(56);
    end
    drain("free_run");

    // short cycle: second fall 60 clk after the first drops write/read
    fall_now(4'b0011); step(30);
    a8_clk = 1'b1;     step(30);
    fall_now(4'hF);    step(56);
    a8_clk = 1'b1;     step(120);
    drain("short_cycle");

    // new fall pulse coincides with the old addr strobe, which is suppressed
    fall_now(4'b0001); step(10);
    a8_clk = 1'b1;     step(22);
    fall_now(4'hF);    step(56);
    a8_clk = 1'b1;     step(60);
    drain("coincide");

    // stopped clock: one full set then silence
    fall_now(4'hF); step(400);
    drain("stopped");
    a8_clk = 1'b1; step(5);

    // reset while the addr strobe is high, then a clean cycle after release
    fall_now(4'b0011); step(DET + A_ADDR);
    a8_rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    step(20);
    a8_clk = 1'b1; step(20);
    a8_clk = 1'b0; step(20);
    a8_clk = 1'b1; step(100);
    chk_zero("reset_mid_held");
    a8_rst_n = 1'b1; step(5);
    fall_now(4'hF); step(56);
    a8_clk = 1'b1;  step(60);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_monitor_core.md
# bus_monitor_core

Sits between the Atari 8-bit (A8) cartridge/expansion bus and the FPGA bus-interface logic. It samples the A8 system clock (~1.79 MHz, 558 ns cycle) in the FPGA clock domain (200 MHz, 5 ns). It produces single-cycle timing strobes that say when the A8 address, write data and read window are valid within each A8 bus cycle. Downstream decoders use these strobes to latch address and data without their own A8-clock timing logic.

## Interface
Parameters:
- ADDR_CYCLES, default 32: clk cycles from the a8_clk_falling pulse to the a8_addr_strobe pulse.
- WRITE_CYCLES, default 81: clk cycles from the a8_clk_falling pulse to the a8_write_strobe pulse.
- READ_CYCLES, default 94: clk cycles from the a8_clk_falling pulse to the a8_read_strobe pulse.
- Constraint: 1 ≤ ADDR_CYCLES < WRITE_CYCLES < READ_CYCLES ≤ 254.

Ports:
- clk  in  1  FPGA clock, 200 MHz. This is the only clock; all logic is on its rising edge.
- a8_rst_n  in  1  A8 bus reset. Asynchronous, active-low.
- a8_clk  in  1  A8 system clock (phi2). Asynchronous; it is treated as data and synchronised.
- a8_addr_strobe  out  1  One-cycle pulse: the A8 address bus is valid.
- a8_write_strobe  out  1  One-cycle pulse: A8 write data and R/W are valid.
- a8_read_strobe  out  1  One-cycle pulse: the latest point to drive or sample read data.
- a8_clk_falling  out  1  One-cycle pulse: an a8_clk falling edge was detected and a new A8 cycle begins.

## Operation
- a8_clk passes through a 2-flop synchroniser (s1, s2) and then a history flop s3.
- Falling-edge detect is s3 & ~s2. It is registered onto a8_clk_falling, so the output is high for exactly one clk cycle.
- Cycle counter: 8-bit cnt plus an `active` flag.
  - On a falling detect: cnt is cleared and active is set.
  - Otherwise, while active, cnt increments each clk cycle and saturates at 255.
  - Once cnt reaches 255 the block stays silent until the next falling edge.
- Strobes are registered decodes of cnt while active:
  - a8_addr_strobe pulses for one cycle ADDR_CYCLES clk cycles after the a8_clk_falling pulse.
  - a8_write_strobe and a8_read_strobe pulse likewise at WRITE_CYCLES and READ_CYCLES.
- Each strobe fires at most once per detected falling edge.
- A new falling edge restarts the count. Any strobe not yet issued for the previous cycle is dropped. If a strobe would coincide with the new a8_clk_falling pulse, the strobe is suppressed.
- Rising edges of a8_clk have no effect.
- Asynchronous reset (a8_rst_n low):
  - s1, s2, s3, cnt and active clear to 0.
  - All four outputs go to 0 immediately and stay 0 while reset is held.
- After reset release:
  - No strobe is issued until the first falling edge is detected.
  - Because s3 resets to 0, a8_clk being low at release produces no spurious falling pulse.
- Reset asserted mid-cycle aborts that cycle; the strobes pending for it are never issued.

## Timing
- Edge-detect latency: a8_clk_falling rises on the 3rd rising clk edge after the a8_clk fall. That is 10–15 ns at 200 MHz, assuming the fall meets setup before the first of those edges.
- Default strobe positions after the true A8 falling edge: address ≈ 170–175 ns, write ≈ 415–420 ns, read ≈ 480–485 ns. These sit at or just before the A8 spec points of 177 / 422 / 486 ns.
- All outputs are registered: glitch-free and one clk cycle wide.
- Jitter relative to the A8 edge is at most 1 clk cycle (5 ns), due to synchronisation.
- A nominal A8 cycle (558 ns, ~111 clk) always completes all three strobes before the next a8_clk_falling.

## Test plan
- Free-running run: clk 5 ns, a8_clk 558 ns period, no reset.
  - Per A8 cycle: exactly one pulse each of a8_clk_falling, addr, write, read, in that order.
  - Pulse spacing: 32, 81 and 94 clk cycles after a8_clk_falling.
  - No pulses between a8_clk rising edge and the next falling edge other than these.
- Reset mid-cycle: pull a8_rst_n low 558–1116 ns.
  - All outputs go 0 asynchronously and no strobes appear during reset.
  - After release, the first a8_clk fall (1674 ns) gives a8_clk_falling at clk edge 1687.5 ns.
  - a8_addr_strobe follows at 1847.5 ns.
- Stopped clock: hold a8_clk low after one fall.
  - One full strobe set is issued, then silence indefinitely (counter saturated).
- Short cycle: a second a8_clk fall 300 ns after the first.
  - Addr strobe is issued for cycle 1; its write and read strobes are dropped.
  - The counter restarts and cycle 2 yields a full strobe set.
- Release with a8_clk low: release reset while a8_clk = 0.
  - No a8_clk_falling until a genuine 1→0 transition is seen.
- Parameter override: ADDR_CYCLES=2, WRITE_CYCLES=3, READ_CYCLES=4.
  - The three strobes appear on consecutive clk cycles, 2/3/4 cycles after a8_clk_falling.
